sdram_init_ctrl: RTL and testbench

SDRAM_INIT_CTRL -- requirements
Module: sdram_init_ctrl

---
 rtl/sdram_init_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_sdram_init_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_ctrl.sv
// sdram_init_ctrl: SDRAM power-up initialisation sequencer.
// The sequence is: power-up wait, PRECHARGE ALL, REFRESH_NUM AUTO REFRESH
// commands, LOAD MODE REGISTER, then a sticky init_done with NOPs forever.
// Macro SDRAM_INIT_FAST_SIM_EN shortens the power-up wait to 20 cycles.
// The DQ bus is left entirely to the data path and is not driven here.
`timescale 1ns/1ps

module sdram_init_ctrl #(
    parameter int unsigned T_POWER     = 10000,
    parameter int unsigned T_RP        = 2,
    parameter int unsigned T_RC        = 7,
    parameter int unsigned T_MRD       = 3,
    parameter int unsigned REFRESH_NUM = 8,
    parameter logic [11:0] MODE_VALUE  = 12'h032
) (
    input  logic        clock,
    input  logic        reset,
    output logic        sdram_clk,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_dqm,
    output logic        init_done
);

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int unsigned TP_EFF = 20;
`else
    localparam int unsigned TP_EFF = T_POWER;
`endif

    localparam int unsigned MAX_A   = (TP_EFF > T_RC) ? TP_EFF : T_RC;
    localparam int unsigned MAX_B   = (T_RP > T_MRD) ? T_RP : T_MRD;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned REF_W   = (REFRESH_NUM < 1) ? 1 : $clog2(REFRESH_NUM + 1);

    // Wait states are entered one cycle after their command, so a spacing
    // of S cycles ends when the counter reaches S-2.
    localparam logic [CNT_W-1:0] POWER_LAST = CNT_W'(TP_EFF);
    localparam logic [CNT_W-1:0] RP_LAST    = CNT_W'((T_RP  >= 2) ? T_RP  - 2 : 0);
    localparam logic [CNT_W-1:0] RC_LAST    = CNT_W'((T_RC  >= 2) ? T_RC  - 2 : 0);
    localparam logic [CNT_W-1:0] MRD_LAST   = CNT_W'((T_MRD >= 2) ? T_MRD - 2 : 0);
    localparam logic [REF_W-1:0] REF_LAST   = REF_W'(REFRESH_NUM);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    typedef enum logic [2:0] {
        WAIT_POWER,
        PRECHARGE,
        WAIT_RP,
        REFRESH,
        WAIT_RC,
        LOAD_MODE,
        WAIT_MRD,
        DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               advance_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [REF_W-1:0]   ref_cnt_q;
    logic [3:0]         cmd_q;
    logic               cke_q;
    logic [1:0]         ba_q;
    logic [11:0]        addr_q;
    logic [1:0]         dqm_q;
    logic               done_q;

    // Next-state selection; advance_d marks every state entry, including a
    // back-to-back command when a spacing is shorter than two cycles.
    always_comb begin
        state_d   = state_q;
        advance_d = 1'b0;
        unique case (state_q)
            WAIT_POWER: begin
                if (cnt_q == POWER_LAST) begin
                    state_d   = PRECHARGE;
                    advance_d = 1'b1;
                end
            end
            PRECHARGE: begin
                advance_d = 1'b1;
                if (T_RP >= 2)
                    state_d = WAIT_RP;
                else if (REFRESH_NUM == 0)
                    state_d = LOAD_MODE;
                else
                    state_d = REFRESH;
            end
            WAIT_RP: begin
                if (cnt_q == RP_LAST) begin
                    advance_d = 1'b1;
                    state_d   = (REFRESH_NUM == 0) ? LOAD_MODE : REFRESH;
                end
            end
            REFRESH: begin
                advance_d = 1'b1;
                if (T_RC >= 2)
                    state_d = WAIT_RC;
                else if (ref_cnt_q == REF_LAST)
                    state_d = LOAD_MODE;
                else
                    state_d = REFRESH;
            end
            WAIT_RC: begin
                if (cnt_q == RC_LAST) begin
                    advance_d = 1'b1;
                    state_d   = (ref_cnt_q == REF_LAST) ? LOAD_MODE : REFRESH;
                end
            end
            LOAD_MODE: begin
                advance_d = 1'b1;
                state_d   = (T_MRD >= 2) ? WAIT_MRD : DONE;
            end
            WAIT_MRD: begin
                if (cnt_q == MRD_LAST) begin
                    advance_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
        endcase
    end

    // State, counters and registered pin outputs; a command is issued on the
    // cycle its state is entered, every other cycle is a NOP with zero address.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= WAIT_POWER;
            cnt_q     <= '0;
            ref_cnt_q <= '0;
            cmd_q     <= CMD_NOP;
            cke_q     <= 1'b0;
            ba_q      <= '0;
            addr_q    <= '0;
            dqm_q     <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cke_q   <= 1'b1;
            cmd_q   <= CMD_NOP;
            ba_q    <= '0;
            addr_q  <= '0;

            if (advance_d)
                cnt_q <= '0;
            else if (state_q != DONE)
                cnt_q <= cnt_q + 1'b1;

            if (advance_d) begin
                unique case (state_d)
                    PRECHARGE: begin
                        cmd_q     <= CMD_PRE;
                        addr_q    <= 12'h400;
                        ref_cnt_q <= '0;
                    end
                    REFRESH: begin
                        cmd_q     <= CMD_REF;
                        ref_cnt_q <= ref_cnt_q + 1'b1;
                    end
                    LOAD_MODE: begin
                        cmd_q     <= CMD_LMR;
                        addr_q    <= MODE_VALUE;
                    end
                    default: begin
                    end
                endcase
            end

            dqm_q  <= (state_d == DONE) ? 2'b00 : 2'b11;
            done_q <= done_q | (state_d == DONE);
        end
    end

    assign sdram_clk   = ~clock;
    assign sdram_cke   = cke_q;
    assign sdram_cs_n  = cmd_q[3];
    assign sdram_ras_n = cmd_q[2];
    assign sdram_cas_n = cmd_q[1];
    assign sdram_we_n  = cmd_q[0];
    assign sdram_ba    = ba_q;
    assign sdram_addr  = addr_q;
    assign sdram_dqm   = dqm_q;
    assign init_done   = done_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Testbench for sdram_init_ctrl: two instances (default parameters and
// REFRESH_NUM=2 / MODE_VALUE=12'h037) checked every cycle against a
// schedule model derived from the command timing rules, with randomized
// reset points mid-sequence and after completion.
`timescale 1ns/1ps

module tb_sdram_init_ctrl;

`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int unsigned TP = 20;
`else
    localparam int unsigned TP = 10000;
`endif
    localparam int unsigned RP  = 2;
    localparam int unsigned RC  = 7;
    localparam int unsigned MRD = 3;
    localparam int unsigned NA  = 8;
    localparam int unsigned NB  = 2;
    localparam int unsigned DONE_A = TP + RP + NA * RC + MRD;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        a_clk, a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_done;
    logic [1:0]  a_ba, a_dqm;
    logic [11:0] a_addr;
    logic        b_clk, b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_done;
    logic [1:0]  b_ba, b_dqm;
    logic [11:0] b_addr;

    int errors = 0;
    int checks = 0;
    int c = -1;
    int n_pre, n_ref, n_lmr, n_late;

    always #10 clock = ~clock;

    sdram_init_ctrl u_dut_a (
        .clock      (clock),
        .reset      (reset),
        .sdram_clk  (a_clk),
        .sdram_cke  (a_cke),
        .sdram_cs_n (a_cs_n),
        .sdram_ras_n(a_ras_n),
        .sdram_cas_n(a_cas_n),
        .sdram_we_n (a_we_n),
        .sdram_ba   (a_ba),
        .sdram_addr (a_addr),
        .sdram_dqm  (a_dqm),
        .init_done  (a_done)
    );

    sdram_init_ctrl #(
        .REFRESH_NUM(NB),
        .MODE_VALUE (12'h037)
    ) u_dut_b (
        .clock      (clock),
        .reset      (reset),
        .sdram_clk  (b_clk),
        .sdram_cke  (b_cke),
        .sdram_cs_n (b_cs_n),
        .sdram_ras_n(b_ras_n),
        .sdram_cas_n(b_cas_n),
        .sdram_we_n (b_we_n),
        .sdram_ba   (b_ba),
        .sdram_addr (b_addr),
        .sdram_dqm  (b_dqm),
        .init_done  (b_done)
    );

    // Expected pin vector {cke, cmd[3:0], ba, addr, dqm, done} for the output
    // cycle c after reset release (c < 0 means reset was sampled high).
    function automatic logic [21:0] model(input int cyc, input int unsigned nref,
                                          input logic [11:0] mode);
        int unsigned u;
        int unsigned t_lmr;
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic        done;
        if (cyc < 0)
            return {1'b0, 4'b0111, 2'b00, 12'h000, 2'b11, 1'b0};
        u     = cyc;
        t_lmr = TP + RP + nref * RC;
        cmd   = 4'b0111;
        addr  = 12'h000;
        if (u == TP) begin
            cmd  = 4'b0010;
            addr = 12'h400;
        end
        for (int unsigned k = 0; k < nref; k++)
            if (u == TP + RP + k * RC)
                cmd = 4'b0001;
        if (u == t_lmr) begin
            cmd  = 4'b0000;
            addr = mode;
        end
        done = (u >= t_lmr + MRD);
        return {1'b1, cmd, 2'b00, addr, done ? 2'b00 : 2'b11, done};
    endfunction

    // Advance one clock: track the cycle index, check both instances at the
    // falling edge and tally instance A's commands.
    task automatic step();
        logic [21:0] exp_a, exp_b, obs_a, obs_b;
        logic [3:0]  cmd_a;
        @(posedge clock);
        if (reset) c = -1;
        else       c = c + 1;
        #1;
        checks++;
        assert ({a_clk, b_clk} === 2'b00) else begin
            errors++;
            $error("FAIL sdram_clk_low c=%0d observed=%b expected=00", c, {a_clk, b_clk});
        end
        @(negedge clock);
        #1;
        obs_a = {a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_ba, a_addr, a_dqm, a_done};
        obs_b = {b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_ba, b_addr, b_dqm, b_done};
        exp_a = model(c, NA, 12'h032);
        exp_b = model(c, NB, 12'h037);
        checks++;
        assert (obs_a === exp_a) else begin
            errors++;
            $error("FAIL pins_a c=%0d observed=%h expected=%h", c, obs_a, exp_a);
        end
        checks++;
        assert (obs_b === exp_b) else begin
            errors++;
            $error("FAIL pins_b c=%0d observed=%h expected=%h", c, obs_b, exp_b);
        end
        checks++;
        assert ({a_clk, b_clk} === 2'b11) else begin
            errors++;
            $error("FAIL sdram_clk_high c=%0d observed=%b expected=11", c, {a_clk, b_clk});
        end
        cmd_a = {a_cs_n, a_ras_n, a_cas_n, a_we_n};
        if (c >= 0) begin
            if (cmd_a == 4'b0010) n_pre++;
            if (cmd_a == 4'b0001) n_ref++;
            if (cmd_a == 4'b0000) n_lmr++;
            if (cmd_a != 4'b0111 && c >= int'(DONE_A)) n_late++;
        end
    endtask

    task automatic clear_tally();
        n_pre = 0; n_ref = 0; n_lmr = 0; n_late = 0;
    endtask

    task automatic check_tally(input string tag);
        checks++;
        assert ({n_pre, n_ref, n_lmr, n_late} === {32'sd1, 32'sd8, 32'sd1, 32'sd0}) else begin
            errors++;
            $error("FAIL %s observed pre=%0d ref=%0d lmr=%0d late=%0d expected pre=1 ref=8 lmr=1 late=0",
                   tag, n_pre, n_ref, n_lmr, n_late);
        end
    endtask

    initial begin
        int r_at;
        int hold;

        // Reset held for 5 cycles: reset pin values every cycle.
        clear_tally();
        reset = 1'b1;
        repeat (5) step();

        // Full initialisation plus 1000 idle cycles after done.
        reset = 1'b0;
        clear_tally();
        while (c < int'(DONE_A) + 1000) step();
        check_tally("tally_first_init");

        // Reset at a random point inside the command phase.
        r_at = int'(TP) + int'($urandom_range(0, 65));
        while (c < r_at) step();
        hold = int'($urandom_range(1, 6));
        reset = 1'b1;
        repeat (hold) step();
        reset = 1'b0;
        clear_tally();
        while (c < int'(DONE_A) + 20) step();
        check_tally("tally_after_mid_reset");

        // Reset after done must restart the whole sequence.
        hold = int'($urandom_range(1, 3));
        reset = 1'b1;
        repeat (hold) step();
        reset = 1'b0;
        clear_tally();
        while (c < int'(DONE_A) + 5) step();
        check_tally("tally_after_done_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
